// File: rtl/rptr_empty_lvl.sv
// Read-side FIFO pointer engine: binary/Gray read pointer, empty/almost-empty flags, fill level.
// Optional underflow status/counter enabled by defining RPTR_UNDERFLOW_ERR_EN.
module rptr_empty_lvl #(
  parameter int ADDRSIZE = 4,
  parameter int UFCNT_W  = 8
) (
  input  logic                i_rclk,
  input  logic                i_rrst,
  input  logic [ADDRSIZE:0]   i_wptr_sync,
  input  logic                i_r_en,
  input  logic [ADDRSIZE:0]   i_aempty_thresh,
  input  logic                i_uf_clr,
  output logic                o_rempty_flag,
  output logic                o_raempty_flag,
  output logic [ADDRSIZE:0]   o_rlevel,
  output logic [ADDRSIZE-1:0] o_raddr,
  output logic [ADDRSIZE-1:0] o_raddr_next,
  output logic [ADDRSIZE:0]   o_rptr,
  output logic                o_rvalid,
  output logic                o_runderflow,
  output logic [UFCNT_W-1:0]  o_uf_cnt
);

  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rgray_q, rgray_d;
  logic [ADDRSIZE:0] level_q, level_d;
  logic [ADDRSIZE:0] wbin_sync;
  logic              rempty_q, raempty_q, rvalid_q;
  logic              rd_fire;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi <= ADDRSIZE; gi++) begin : g_gray2bin
    assign wbin_sync[gi] = ^i_wptr_sync[ADDRSIZE:gi];
  end

  assign rd_fire = i_r_en & ~rempty_q;

  always_comb begin
    rbin_d  = rbin_q + {{ADDRSIZE{1'b0}}, rd_fire};
    rgray_d = (rbin_d >> 1) ^ rbin_d;
    level_d = wbin_sync - rbin_d;
  end

  always_ff @(posedge i_rclk) begin
    if (i_rrst) begin
      rbin_q    <= '0;
      rgray_q   <= '0;
      level_q   <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      rvalid_q  <= 1'b0;
    end else begin
      rbin_q    <= rbin_d;
      rgray_q   <= rgray_d;
      level_q   <= level_d;
      // Next-state compare lets a read of the last entry assert empty on the same edge.
      rempty_q  <= (rgray_d == i_wptr_sync);
      raempty_q <= (level_d <= i_aempty_thresh);
      rvalid_q  <= rd_fire;
    end
  end

  assign o_rempty_flag  = rempty_q;
  assign o_raempty_flag = raempty_q;
  assign o_rlevel       = level_q;
  assign o_raddr        = rbin_q[ADDRSIZE-1:0];
  assign o_raddr_next   = rbin_d[ADDRSIZE-1:0];
  assign o_rptr         = rgray_q;
  assign o_rvalid       = rvalid_q;

`ifdef RPTR_UNDERFLOW_ERR_EN
  logic               uf_evt;
  logic               runderflow_q;
  logic [UFCNT_W-1:0] uf_cnt_q;

  assign uf_evt = i_r_en & rempty_q;

  always_ff @(posedge i_rclk) begin
    if (i_rrst || i_uf_clr) begin
      runderflow_q <= 1'b0;
      uf_cnt_q     <= '0;
    end else if (uf_evt) begin
      runderflow_q <= 1'b1;
      if (uf_cnt_q != {UFCNT_W{1'b1}}) begin
        uf_cnt_q <= uf_cnt_q + 1'b1;
      end
    end
  end

  assign o_runderflow = runderflow_q;
  assign o_uf_cnt     = uf_cnt_q;
`else
  logic unused_uf_clr;

  assign unused_uf_clr = i_uf_clr;
  assign o_runderflow  = 1'b0;
  assign o_uf_cnt      = '0;
`endif

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Bench for rptr_empty_lvl (ADDRSIZE=4): directed scenarios plus randomized traffic
// checked against a count-based FIFO occupancy model.
module tb_rptr_empty_lvl;

  logic       clk = 1'b0;
  logic       rrst, r_en, uf_clr;
  logic [4:0] wptr_sync, thresh;
  logic       empty, aempty, rvalid, underflow;
  logic [4:0] level, rptr;
  logic [3:0] raddr, raddr_next;
  logic [7:0] uf_cnt;

  int wcnt = 0;
  int n_checks = 0;
  int n_errors = 0;

  // Reference model: read count, occupancy and flags derived from counts.
  int m_rcnt = 0, m_level = 0, m_ufcnt = 0;
  bit m_empty = 1, m_aempty = 1, m_rvalid = 0, m_uf = 0;

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  assign wptr_sync = gray5(wcnt);

  always #5 clk = ~clk;

  rptr_empty_lvl #(.ADDRSIZE(4), .UFCNT_W(8)) dut (
    .i_rclk(clk), .i_rrst(rrst), .i_wptr_sync(wptr_sync), .i_r_en(r_en),
    .i_aempty_thresh(thresh), .i_uf_clr(uf_clr),
    .o_rempty_flag(empty), .o_raempty_flag(aempty), .o_rlevel(level),
    .o_raddr(raddr), .o_raddr_next(raddr_next), .o_rptr(rptr),
    .o_rvalid(rvalid), .o_runderflow(underflow), .o_uf_cnt(uf_cnt)
  );

  task automatic step();
    bit fire, uf;
    @(posedge clk);
    fire = r_en && !m_empty;
    uf   = r_en && m_empty;
    if (rrst) begin
      m_rcnt = 0; m_level = 0; m_empty = 1; m_aempty = 1; m_rvalid = 0;
      m_uf = 0; m_ufcnt = 0;
    end else begin
      m_rcnt   = (m_rcnt + int'(fire)) % 32;
      m_level  = ((wcnt - m_rcnt) % 32 + 32) % 32;
      m_empty  = (m_level == 0);
      m_aempty = (m_level <= int'(thresh));
      m_rvalid = fire;
`ifdef RPTR_UNDERFLOW_ERR_EN
      if (uf_clr) begin
        m_uf = 0; m_ufcnt = 0;
      end else if (uf) begin
        m_uf = 1;
        if (m_ufcnt < 255) m_ufcnt++;
      end
`endif
    end
    #1;
    $display("cycle rst=%0b ren=%0b wptr=%05b rptr=%05b lvl=%0d empty=%0b aempty=%0b rvalid=%0b uf=%0b ufcnt=%0d",
             rrst, r_en, wptr_sync, rptr, level, empty, aempty, rvalid, underflow, uf_cnt);
  endtask

  task automatic do_reset();
    rrst = 1; r_en = 0; uf_clr = 0; wcnt = 0;
    step();
    rrst = 0;
  endtask

  task automatic test_reset();
    rrst = 1; r_en = 1; uf_clr = 0; thresh = 5'd2; wcnt = 3;
    step();
    step();
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
    n_checks++; if (rptr !== 5'd0) begin n_errors++; $display("FAIL reset_rptr: got %05b expected 00000", rptr); end
    n_checks++; if (level !== 5'd0) begin n_errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_checks++; if (aempty !== 1'b1) begin n_errors++; $display("FAIL reset_aempty: got %0b expected 1", aempty); end
    n_checks++; if (rvalid !== 1'b0) begin n_errors++; $display("FAIL reset_rvalid: got %0b expected 0", rvalid); end
    n_checks++; if ({underflow, uf_cnt} !== 9'd0) begin n_errors++; $display("FAIL reset_uf: got %0b/%0d expected 0/0", underflow, uf_cnt); end
  endtask

  task automatic test_drain3();
    logic [4:0] exp_rptr [3];
    exp_rptr[0] = 5'b00001; exp_rptr[1] = 5'b00011; exp_rptr[2] = 5'b00010;
    rrst = 0; r_en = 1; wcnt = 3;
    step();
    n_checks++; if (empty !== 1'b0) begin n_errors++; $display("FAIL drain_empty0: got %0b expected 0", empty); end
    n_checks++; if (level !== 5'd3) begin n_errors++; $display("FAIL drain_level0: got %0d expected 3", level); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (rptr !== exp_rptr[i]) begin n_errors++; $display("FAIL drain_rptr[%0d]: got %05b expected %05b", i, rptr, exp_rptr[i]); end
      n_checks++; if (rvalid !== 1'b1) begin n_errors++; $display("FAIL drain_rvalid[%0d]: got %0b expected 1", i, rvalid); end
      n_checks++; if (empty !== (i == 2)) begin n_errors++; $display("FAIL drain_empty[%0d]: got %0b expected %0b", i, empty, i == 2); end
    end
    step();
    n_checks++; if (rvalid !== 1'b0) begin n_errors++; $display("FAIL drain_rvalid_end: got %0b expected 0", rvalid); end
    n_checks++; if (rptr !== 5'b00010) begin n_errors++; $display("FAIL drain_rptr_hold: got %05b expected 00010", rptr); end
    r_en = 0;
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    bit saw_wrap = 0;
    do_reset();
    prev = rptr;
    for (int i = 0; i < 40; i++) begin
      wcnt = (wcnt + 1) % 32; r_en = 1;
      step();
      if (prev == 5'b10000 && rptr == 5'b00000) saw_wrap = 1;
      prev = rptr;
      n_checks++; if (rptr !== gray5(m_rcnt)) begin n_errors++; $display("FAIL wrap_rptr[%0d]: got %05b expected %05b", i, rptr, gray5(m_rcnt)); end
      n_checks++; if ({empty, level} !== {m_empty, 5'(m_level)}) begin n_errors++; $display("FAIL wrap_state[%0d]: got empty=%0b lvl=%0d expected empty=%0b lvl=%0d", i, empty, level, m_empty, m_level); end
    end
    n_checks++; if (saw_wrap !== 1'b1) begin n_errors++; $display("FAIL wrap_seen: got %0b expected 1", saw_wrap); end
    r_en = 0;
  endtask

  task automatic test_full_level();
    do_reset();
    thresh = 5'd2; wcnt = 16;
    step();
    n_checks++; if (level !== 5'd16) begin n_errors++; $display("FAIL full_level: got %0d expected 16", level); end
    n_checks++; if (empty !== 1'b0) begin n_errors++; $display("FAIL full_empty: got %0b expected 0", empty); end
    n_checks++; if (aempty !== 1'b0) begin n_errors++; $display("FAIL full_aempty: got %0b expected 0", aempty); end
  endtask

  task automatic test_almost_empty();
    do_reset();
    thresh = 5'd2; wcnt = 3;
    step();
    n_checks++; if ({aempty, level} !== {1'b0, 5'd3}) begin n_errors++; $display("FAIL aempty_pre: got aempty=%0b lvl=%0d expected 0/3", aempty, level); end
    r_en = 1;
    step();
    r_en = 0;
    n_checks++; if (aempty !== 1'b1) begin n_errors++; $display("FAIL aempty_set: got %0b expected 1", aempty); end
    n_checks++; if (level !== 5'd2) begin n_errors++; $display("FAIL aempty_level: got %0d expected 2", level); end
  endtask

  task automatic test_underflow();
    bit         exp_uf;
    logic [7:0] exp_cnt, exp_sat;
`ifdef RPTR_UNDERFLOW_ERR_EN
    exp_uf = 1; exp_cnt = 8'd3; exp_sat = 8'd255;
`else
    exp_uf = 0; exp_cnt = 8'd0; exp_sat = 8'd0;
`endif
    do_reset();
    step();
    r_en = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if ({rptr, rvalid} !== 6'd0) begin n_errors++; $display("FAIL uf_rptr[%0d]: got rptr=%05b rvalid=%0b expected 00000/0", i, rptr, rvalid); end
    end
    n_checks++; if (underflow !== exp_uf) begin n_errors++; $display("FAIL uf_flag: got %0b expected %0b", underflow, exp_uf); end
    n_checks++; if (uf_cnt !== exp_cnt) begin n_errors++; $display("FAIL uf_cnt: got %0d expected %0d", uf_cnt, exp_cnt); end
    r_en = 0; uf_clr = 1;
    step();
    n_checks++; if ({underflow, uf_cnt} !== 9'd0) begin n_errors++; $display("FAIL uf_clear: got %0b/%0d expected 0/0", underflow, uf_cnt); end
    r_en = 1;
    step();
    n_checks++; if ({underflow, uf_cnt} !== 9'd0) begin n_errors++; $display("FAIL uf_clear_wins: got %0b/%0d expected 0/0", underflow, uf_cnt); end
    uf_clr = 0;
    for (int i = 0; i < 260; i++) step();
    n_checks++; if ({underflow, uf_cnt} !== {exp_uf, exp_sat}) begin n_errors++; $display("FAIL uf_saturate: got %0b/%0d expected %0b/%0d", underflow, uf_cnt, exp_uf, exp_sat); end
    r_en = 0;
  endtask

  task automatic test_random();
    int room, adv;
    logic [3:0] exp_next;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        rrst = 1; wcnt = 0;
      end else begin
        rrst = 0;
        room = 16 - (((wcnt - m_rcnt) % 32 + 32) % 32);
        adv  = $urandom_range(0, 2);
        if (adv > room) adv = room;
        wcnt = (wcnt + adv) % 32;
      end
      r_en   = 1'($urandom_range(0, 1));
      uf_clr = ($urandom_range(0, 15) == 0);
      thresh = 5'($urandom_range(0, 16));
      step();
      exp_next = 4'((m_rcnt + int'(r_en && !m_empty)) % 16);
      n_checks++; if (rptr !== gray5(m_rcnt)) begin n_errors++; $display("FAIL rand_rptr[%0d]: got %05b expected %05b", i, rptr, gray5(m_rcnt)); end
      n_checks++; if (level !== 5'(m_level)) begin n_errors++; $display("FAIL rand_level[%0d]: got %0d expected %0d", i, level, m_level); end
      n_checks++; if ({empty, aempty, rvalid} !== {m_empty, m_aempty, m_rvalid}) begin n_errors++; $display("FAIL rand_flags[%0d]: got e/ae/v=%0b%0b%0b expected %0b%0b%0b", i, empty, aempty, rvalid, m_empty, m_aempty, m_rvalid); end
      n_checks++; if ({raddr, raddr_next} !== {4'(m_rcnt % 16), exp_next}) begin n_errors++; $display("FAIL rand_raddr[%0d]: got %0d/%0d expected %0d/%0d", i, raddr, raddr_next, m_rcnt % 16, exp_next); end
      n_checks++; if ({underflow, uf_cnt} !== {m_uf, 8'(m_ufcnt)}) begin n_errors++; $display("FAIL rand_uf[%0d]: got %0b/%0d expected %0b/%0d", i, underflow, uf_cnt, m_uf, m_ufcnt); end
    end
    rrst = 0; r_en = 0; uf_clr = 0;
  endtask

  initial begin
    rrst = 1; r_en = 0; uf_clr = 0; thresh = 5'd2;
    test_reset();
    test_drain3();
    test_wrap();
    test_full_level();
    test_almost_empty();
    test_underflow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
